// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/result bundle between the issue controller
// and its surroundings (instruction source on one side, combinational ALU on the other).
interface alu_issue_ctrl_if #(
  parameter int AW = 2,
  parameter int DW = 8
);
  logic [3+3*AW-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        alu_op;
  logic [DW-1:0]     alu_in1;
  logic [DW-1:0]     alu_in2;
  logic [DW-1:0]     alu_out;
  logic              alu_zero;

  modport slave (
    input  instr, instr_valid, alu_out, alu_zero,
    output instr_ready, alu_op, alu_in1, alu_in2
  );

  modport master (
    output instr, instr_valid, alu_out, alu_zero,
    input  instr_ready, alu_op, alu_in1, alu_in2
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accepts an instruction, reads operands from a small
// register file, drives the ALU for one cycle and writes the captured result back.
module alu_issue_ctrl #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_ctrl_if.slave      bus,
  input  logic                 i_err_clr,
  output logic                 o_done,
  output logic                 o_zero_flag,
  output logic                 o_illegal,
  input  logic [AW-1:0]        i_dbg_addr,
  output logic [DW-1:0]        o_dbg_data
);
  localparam int       IW     = 3 + 3*AW;
  localparam int       NREG   = 2**AW;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_instr;
  logic [DW-1:0]   r_rf [NREG];
  logic [DW-1:0]   r_op_a;
  logic [DW-1:0]   r_op_b;
  logic [2:0]      r_alu_op;
  logic [DW-1:0]   r_res;
  logic            r_zflag_tmp;
  logic            r_zero_flag;
  logic            r_illegal;

  logic            w_ready;
  logic            w_done;
  logic            w_accept;
  logic            w_wr_en;
  logic [2:0]      w_op;
  logic [AW-1:0]   w_rd;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;

  assign w_op     = r_instr[IW-1 -: 3];
  assign w_rd     = r_instr[3*AW-1 -: AW];
  assign w_rs1    = r_instr[2*AW-1 -: AW];
  assign w_rs2    = r_instr[AW-1:0];
  assign w_accept = bus.instr_valid & w_ready;
  assign w_wr_en  = (r_state == S_WB) && (w_op != OP_ILL);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) w_state_next = S_FETCH;
      end
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WB;
      S_WB: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_instr <= bus.instr;
    end
  end

  // Operand registers double as the ALU input ports, so they hold outside FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_alu_op    <= '0;
      r_res       <= '0;
      r_zflag_tmp <= 1'b0;
    end else begin
      if (r_state == S_FETCH) begin
        r_op_a   <= r_rf[w_rs1];
        r_op_b   <= r_rf[w_rs2];
        r_alu_op <= w_op;
      end
      if (r_state == S_EXEC) begin
        r_res       <= bus.alu_out;
        r_zflag_tmp <= bus.alu_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_zero_flag <= 1'b0;
    end else if (w_wr_en) begin
      r_rf[w_rd]  <= r_res;
      r_zero_flag <= r_zflag_tmp;
    end
  end

  // Setting on an illegal write-back takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_WB) && (w_op == OP_ILL)) begin
      r_illegal <= 1'b1;
    end else if (i_err_clr) begin
      r_illegal <= 1'b0;
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_in1     = r_op_a;
  assign bus.alu_in2     = r_op_b;
  assign o_done          = w_done;
  assign o_zero_flag     = r_zero_flag;
  assign o_illegal       = r_illegal;
  assign o_dbg_data      = r_rf[i_dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU attached.
module tb_alu_issue_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          err_clr = 1'b0;
  logic          done;
  logic          zero_flag;
  logic          illegal;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic [DW-1:0] alu_res;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] m_rf [4];
  logic          exp_z = 1'b0;
  logic [2:0]    e_op;
  logic [DW-1:0] e_in1, e_in2;

  alu_issue_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  alu_issue_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .i_err_clr  (err_clr),
    .o_done     (done),
    .o_zero_flag(zero_flag),
    .o_illegal  (illegal),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      3'b000: alu_res = bus.alu_in1 + 8'd1;
      3'b001: alu_res = bus.alu_in1 - 8'd1;
      3'b010: alu_res = bus.alu_in1 ^ bus.alu_in2;
      3'b011: alu_res = {7'b0, ^bus.alu_in1};
      3'b100: alu_res = bus.alu_in1 << bus.alu_in2;
      3'b101: alu_res = bus.alu_in1 >> bus.alu_in2;
      3'b110: alu_res = bus.alu_in1 & bus.alu_in2;
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_out  = alu_res;
  assign bus.alu_zero = (alu_res == '0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a falling edge with the DUT idle; returns at a falling edge, idle again.
  task automatic issue(input logic [8:0] ins, input logic [7:0] exp_res, input logic exp_zero,
                       input logic clr_in_wb);
    logic [1:0] rd;
    logic       legal;
    rd    = ins[5:4];
    legal = (ins[8:6] != 3'b111);
    dbg_addr = rd;
    check("ready_idle", 32'(bus.instr_ready), 32'd1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    check("ready_fetch", 32'(bus.instr_ready), 32'd0);
    check("done_fetch", 32'(done), 32'd0);
    @(negedge clk);
    e_op = bus.alu_op; e_in1 = bus.alu_in1; e_in2 = bus.alu_in2;
    check("done_exec", 32'(done), 32'd0);
    @(negedge clk);
    check("done_wb", 32'(done), 32'd1);
    check("dbg_old_wb", 32'(dbg_data), 32'(m_rf[rd]));
    if (clr_in_wb) err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("done_after", 32'(done), 32'd0);
    check("ready_after", 32'(bus.instr_ready), 32'd1);
    if (legal) begin
      m_rf[rd] = exp_res;
      exp_z    = exp_zero;
    end else begin
      check("illegal_set", 32'(illegal), 32'd1);
    end
    check("rf_wb", 32'(dbg_data), 32'(m_rf[rd]));
    check("zero_flag", 32'(zero_flag), 32'(exp_z));
    $display("instr=%03h rd=%0d dbg=%02h zf=%0b ill=%0b", ins, rd, dbg_data, zero_flag, illegal);
  endtask

  initial begin
    int accepts;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_aluop", 32'(bus.alu_op), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_zf", 32'(zero_flag), 32'd0);
    check("rst_in1", 32'(bus.alu_in1), 32'd0);
    check("rst_in2", 32'(bus.alu_in2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 check("rst_rf", 32'(dbg_data), 32'd0);
    end

    issue(9'h014, 8'h01, 1'b0, 1'b0);
    issue(9'h014, 8'h02, 1'b0, 1'b0);
    issue(9'h014, 8'h03, 1'b0, 1'b0);
    issue(9'h040, 8'hFF, 1'b0, 1'b0);
    issue(9'h0A5, 8'h00, 1'b1, 1'b0);
    issue(9'h054, 8'h02, 1'b0, 1'b0);
    issue(9'h135, 8'h08, 1'b0, 1'b0);
    check("shl_op", 32'(e_op), 32'd4);
    check("shl_in1", 32'(e_in1), 32'd2);
    check("shl_in2", 32'(e_in2), 32'd2);

    issue(9'h1F0, 8'h00, 1'b0, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(illegal), 32'd0);
    issue(9'h1F0, 8'h00, 1'b0, 1'b1);
    check("clr_vs_set", 32'(illegal), 32'd1);

    // Back-to-back requests: ready must pulse once every four cycles.
    accepts = 0;
    dbg_addr = 2'd1;
    bus.instr = 9'h014;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic took;
      took = bus.instr_ready;
      check("hold_ready", 32'(took), 32'((k % 4) == 0));
      if (took) accepts++;
      @(posedge clk);
      #1 if (took) bus.instr = (bus.instr == 9'h014) ? 9'h054 : 9'h014;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check("hold_accepts", 32'(accepts), 32'd4);
    check("hold_r1", 32'(dbg_data), 32'd2);
    $display("hold: accepts=%0d r1=%02h", accepts, dbg_data);

    // Reset in the middle of an instruction.
    bus.instr = 9'h014;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec_op", 32'(bus.alu_op), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.instr_ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_illegal", 32'(illegal), 32'd0);
    check("arst_in1", 32'(bus.alu_in1), 32'd0);
    check("arst_r1", 32'(dbg_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
    end
    check("post_rst_r1", 32'(dbg_data), 32'd0);
    check("post_rst_zf", 32'(zero_flag), 32'd0);
    $display("reset mid-op: r1=%02h", dbg_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
